// File: rtl/xmit_frame_gen.sv
// rtl/xmit_frame_gen.sv - programmable hi/lo frame source for the transmit path
`timescale 1ns/1ps

module xmit_frame_gen #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 12,
  parameter int LOOP_W = 16,
  parameter int GAP_W  = 8,
  parameter int WEIGHT = 3
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [LOOP_W-1:0]    num_loops,
  input  logic [LEN_W-1:0]     len_hi,
  input  logic [LEN_W-1:0]     len_lo,
  input  logic [DATA_W-1:0]    seed_hi,
  input  logic [DATA_W-1:0]    seed_lo,
  input  logic [GAP_W-1:0]     gap,
  input  logic                 pause,
  output logic [DATA_W-1:0]    f_data_in,
  output logic [2*LEN_W-1:0]   f_ctrl_in,
  output logic                 f_rec_data_valid,
  output logic                 f_rec_frame_valid,
  output logic                 f_hi_priority,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {S_IDLE, S_FRAME, S_GAP, S_HOLD, S_DONE} state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [LOOP_W-1:0]   r_num_loops;
  logic [LEN_W-1:0]    r_len_hi;
  logic [LEN_W-1:0]    r_len_lo;
  logic [GAP_W-1:0]    r_gap;
  logic [DATA_W-1:0]   r_seed_hi;
  logic [DATA_W-1:0]   r_seed_lo;
  logic [LOOP_W-1:0]   r_loop_cnt;
  logic [8:0]          r_pos;
  logic [LEN_W-1:0]    r_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [DATA_W-1:0]   r_data;
  logic [2*LEN_W-1:0]  r_ctrl;
  logic                r_dv;
  logic                r_fv;
  logic                r_hi;
  logic                r_busy;
  logic                r_done;

  logic [8:0]          w_loop_frames;
  logic                w_frame_end;
  logic                w_loop_end;
  logic                w_run_over;
  logic [8:0]          w_pos_nx;
  logic [DATA_W-1:0]   w_seed_hi_nx;
  logic [DATA_W-1:0]   w_seed_lo_nx;
  logic [LOOP_W-1:0]   w_loop_cnt_nx;
  logic                w_nx_hi;
  logic [LEN_W-1:0]    w_nx_len_raw;
  logic [LEN_W-1:0]    w_nx_len;
  logic                w_launch;

  // Channel of the frame at position p within one loop of the schedule
  function automatic logic chan_hi(input logic [1:0] m, input logic [8:0] p);
    case (m)
      2'd0:    chan_hi = (p == 9'd0);
      2'd1:    chan_hi = 1'b1;
      2'd2:    chan_hi = 1'b0;
      default: chan_hi = (p < 9'(WEIGHT));
    endcase
  endfunction

  // Frames per loop, and the schedule/seed state as it will be after the current cycle
  always_comb begin
    w_loop_frames = 9'd1;
    case (r_mode)
      2'd0:    w_loop_frames = 9'd2;
      2'd3:    w_loop_frames = 9'(WEIGHT + 1);
      default: w_loop_frames = 9'd1;
    endcase
    w_frame_end   = (r_state == S_FRAME) && (r_cnt == LEN_W'(1));
    w_loop_end    = w_frame_end && (r_pos == w_loop_frames - 9'd1);
    w_pos_nx      = w_frame_end ? (w_loop_end ? 9'd0 : r_pos + 9'd1) : r_pos;
    w_seed_hi_nx  = (w_frame_end && r_hi)  ? r_seed_hi + DATA_W'(1) : r_seed_hi;
    w_seed_lo_nx  = (w_frame_end && !r_hi) ? r_seed_lo + DATA_W'(1) : r_seed_lo;
    w_loop_cnt_nx = w_loop_end ? r_loop_cnt + LOOP_W'(1) : r_loop_cnt;
    w_run_over    = w_loop_end && (w_loop_cnt_nx == r_num_loops);
    w_nx_hi       = chan_hi(r_mode, w_pos_nx);
    w_nx_len_raw  = w_nx_hi ? r_len_hi : r_len_lo;
    w_nx_len      = (w_nx_len_raw == '0) ? LEN_W'(1) : w_nx_len_raw;
    // A new frame starts on the next edge from any of these situations
    w_launch = ((r_state == S_IDLE) && r_busy && (r_num_loops != '0)) ||
               (w_frame_end && !w_run_over && (r_gap == '0) && !pause) ||
               ((r_state == S_GAP) && (r_gap_cnt == GAP_W'(1)) && !pause) ||
               ((r_state == S_HOLD) && !pause);
  end

  // Run sequencer: state, schedule bookkeeping and registered outputs
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mode      <= '0;
      r_num_loops <= '0;
      r_len_hi    <= '0;
      r_len_lo    <= '0;
      r_gap       <= '0;
      r_seed_hi   <= '0;
      r_seed_lo   <= '0;
      r_loop_cnt  <= '0;
      r_pos       <= '0;
      r_cnt       <= '0;
      r_gap_cnt   <= '0;
      r_data      <= '0;
      r_ctrl      <= '0;
      r_dv        <= 1'b0;
      r_fv        <= 1'b0;
      r_hi        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_dv       <= 1'b0;
      r_fv       <= 1'b0;
      r_ctrl     <= '0;
      r_data     <= '0;
      r_hi       <= 1'b0;
      r_seed_hi  <= w_seed_hi_nx;
      r_seed_lo  <= w_seed_lo_nx;
      r_pos      <= w_pos_nx;
      r_loop_cnt <= w_loop_cnt_nx;
      case (r_state)
        S_IDLE: begin
          if (r_busy) begin
            if (r_num_loops == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else if (start) begin
            r_mode      <= mode;
            r_num_loops <= num_loops;
            r_len_hi    <= len_hi;
            r_len_lo    <= len_lo;
            r_gap       <= gap;
            r_seed_hi   <= seed_hi;
            r_seed_lo   <= seed_lo;
            r_pos       <= '0;
            r_loop_cnt  <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_FRAME: begin
          if (w_frame_end) begin
            if (w_run_over) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_gap != '0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= r_gap;
            end else begin
              r_state <= S_HOLD;
            end
          end else begin
            r_cnt  <= r_cnt - LEN_W'(1);
            r_dv   <= 1'b1;
            r_data <= r_data;
            r_hi   <= r_hi;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_W'(1)) r_state <= S_HOLD;
          else r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
        S_HOLD:  r_state <= S_HOLD;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_launch) begin
        r_state <= S_FRAME;
        r_cnt   <= w_nx_len;
        r_dv    <= 1'b1;
        r_fv    <= 1'b1;
        r_ctrl  <= {w_nx_len, w_nx_len};
        r_data  <= w_nx_hi ? w_seed_hi_nx : w_seed_lo_nx;
        r_hi    <= w_nx_hi;
      end
    end
  end

  assign f_data_in         = r_data;
  assign f_ctrl_in         = r_ctrl;
  assign f_rec_data_valid  = r_dv;
  assign f_rec_frame_valid = r_fv;
  assign f_hi_priority     = r_hi;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

// File: tb/tb_xmit_frame_gen.sv
// tb/tb_xmit_frame_gen.sv - self-checking bench for xmit_frame_gen
`timescale 1ns/1ps

module tb_xmit_frame_gen;

  localparam int WEIGHT = 3;

  typedef logic [36:0] tup_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [15:0] num_loops = '0;
  logic [11:0] len_hi = '0;
  logic [11:0] len_lo = '0;
  logic [7:0]  seed_hi = '0;
  logic [7:0]  seed_lo = '0;
  logic [7:0]  gap = '0;
  logic        pause = 1'b0;
  logic [7:0]  f_data_in;
  logic [23:0] f_ctrl_in;
  logic        f_rec_data_valid;
  logic        f_rec_frame_valid;
  logic        f_hi_priority;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  tup_t q[$];

  xmit_frame_gen dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .mode(mode),
    .num_loops(num_loops), .len_hi(len_hi), .len_lo(len_lo),
    .seed_hi(seed_hi), .seed_lo(seed_lo), .gap(gap), .pause(pause),
    .f_data_in(f_data_in), .f_ctrl_in(f_ctrl_in),
    .f_rec_data_valid(f_rec_data_valid), .f_rec_frame_valid(f_rec_frame_valid),
    .f_hi_priority(f_hi_priority), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic tup_t mk(input logic b, input logic d, input logic dv, input logic fv,
                              input logic hi, input logic [7:0] data, input logic [23:0] ctrl);
    return {b, d, dv, fv, hi, data, ctrl};
  endfunction

  function automatic tup_t act();
    return {busy, done, f_rec_data_valid, f_rec_frame_valid, f_hi_priority, f_data_in, f_ctrl_in};
  endfunction

  task automatic chk(input string tag, input tup_t obs, input tup_t exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected cycle-by-cycle output trace of one run, built from the frame schedule
  task automatic build_trace(input int m, input int nl, input int lh, input int ll,
                             input int sh, input int sl, input int g);
    int chans[$];
    int total;
    int idx;
    int len;
    int sd_hi;
    int sd_lo;
    logic [11:0] l12;
    logic [7:0] sd;
    q.delete();
    q.push_back(mk(1, 0, 0, 0, 0, 8'h00, 24'h0));
    if (nl == 0) begin
      q.push_back(mk(0, 1, 0, 0, 0, 8'h00, 24'h0));
      q.push_back(mk(0, 1, 0, 0, 0, 8'h00, 24'h0));
      return;
    end
    case (m)
      0: begin chans.push_back(1); chans.push_back(0); end
      1: chans.push_back(1);
      2: chans.push_back(0);
      default: begin
        for (int w = 0; w < WEIGHT; w++) chans.push_back(1);
        chans.push_back(0);
      end
    endcase
    total = nl * chans.size();
    idx = 0;
    sd_hi = sh;
    sd_lo = sl;
    for (int l = 0; l < nl; l++) begin
      foreach (chans[c]) begin
        len = (chans[c] == 1) ? lh : ll;
        if (len == 0) len = 1;
        l12 = len[11:0];
        sd = (chans[c] == 1) ? sd_hi[7:0] : sd_lo[7:0];
        for (int k = 0; k < len; k++)
          q.push_back(mk(1, 0, 1, k == 0, chans[c] == 1, sd, (k == 0) ? {l12, l12} : 24'h0));
        if (chans[c] == 1) sd_hi = (sd_hi + 1) % 256;
        else sd_lo = (sd_lo + 1) % 256;
        idx++;
        if (idx < total)
          for (int k = 0; k < g; k++) q.push_back(mk(1, 0, 0, 0, 0, 8'h00, 24'h0));
      end
    end
    q.push_back(mk(0, 1, 0, 0, 0, 8'h00, 24'h0));
    q.push_back(mk(0, 1, 0, 0, 0, 8'h00, 24'h0));
  endtask

  task automatic consume(input string tag, input int n);
    tup_t exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      if (q.size() == 0) begin
        chk({tag, "_underrun"}, act(), 37'h0);
      end else begin
        exp = q.pop_front();
        chk(tag, act(), exp);
      end
    end
  endtask

  task automatic drive_start(input string tag, input int m, input int nl, input int lh,
                             input int ll, input int sh, input int sl, input int g);
    build_trace(m, nl, lh, ll, sh, sl, g);
    @(negedge clk_sys);
    mode = m[1:0];
    num_loops = nl[15:0];
    len_hi = lh[11:0];
    len_lo = ll[11:0];
    seed_hi = sh[7:0];
    seed_lo = sl[7:0];
    gap = g[7:0];
    start = 1'b1;
    consume(tag, 1);
    start = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_state", act(), 37'h0);
    @(negedge clk_sys);
    reset = 1'b1;

    drive_start("alternate", 0, 2, 'h200, 'h040, 'hF0, 'h00, 0);
    consume("alternate", q.size());

    drive_start("weighted", 3, 1, 4, 4, 'h11, 'h22, 2);
    consume("weighted", q.size());

    drive_start("pause", 1, 2, 8, 8, 'h40, 'h00, 0);
    consume("pause_frame", 6);
    pause = 1'b1;
    consume("pause_frame", 2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      chk("pause_hold", act(), mk(1, 0, 0, 0, 0, 8'h00, 24'h0));
    end
    pause = 1'b0;
    consume("pause_resume", q.size());

    drive_start("zero_loops", 0, 0, 5, 5, 'h01, 'h02, 1);
    consume("zero_loops", q.size());

    drive_start("len_zero", 1, 1, 0, 5, 'h33, 'h00, 0);
    consume("len_zero", q.size());

    drive_start("seed_wrap", 2, 2, 3, 3, 'h00, 'hFF, 1);
    consume("seed_wrap", q.size());

    drive_start("busy_start", 0, 1, 6, 5, 'h10, 'h20, 0);
    consume("busy_start", 3);
    start = 1'b1;
    mode = 2'd1;
    len_hi = 12'd9;
    len_lo = 12'd9;
    consume("busy_start", 1);
    start = 1'b0;
    consume("busy_start", q.size());

    drive_start("pre_reset", 1, 3, 'h20, 4, 'h5A, 'h00, 0);
    consume("pre_reset", 10);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", act(), 37'h0);
    q.delete();
    @(negedge clk_sys);
    reset = 1'b1;
    drive_start("post_reset", 1, 1, 'h20, 4, 'h5A, 'h00, 0);
    consume("post_reset", q.size());

    for (int r = 0; r < 8; r++) begin
      drive_start("random", $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6),
                  $urandom_range(0, 6), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 3));
      consume("random", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
